// File: rtl/vga_draw_sequencer.sv
// Clears a fixed screen rectangle, then arms the pipeline drawer and forwards its
// pixels to the VGA adapter until it reports done or times out.
module vga_draw_sequencer #(
  parameter int          CLEAR_X0     = 300,
  parameter int          CLEAR_Y0     = 25,
  parameter int          CLEAR_W      = 117,
  parameter int          CLEAR_H      = 68,
  parameter logic [8:0]  BG_COLOR     = 9'b000000000,
  parameter int          DRAW_TIMEOUT = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        refresh_req,
  input  logic [9:0]  pipeline_x,
  input  logic [8:0]  pipeline_y,
  input  logic [8:0]  pipeline_color,
  input  logic        pipeline_done,
  output logic        drawer_resetn,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [8:0]  vga_color,
  output logic        vga_write,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] frame_count
);

  localparam int TW = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;
  localparam logic [9:0]    X0_L    = 10'(CLEAR_X0);
  localparam logic [8:0]    Y0_L    = 9'(CLEAR_Y0);
  localparam logic [9:0]    CX_LAST = 10'(CLEAR_W - 1);
  localparam logic [8:0]    CY_LAST = 9'(CLEAR_H - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(DRAW_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ARM    = 3'd2,
    ST_DRAW   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [9:0]      cx_r, cx_s;
  logic [8:0]      cy_r, cy_s;
  logic [TW-1:0]   tcnt_r, tcnt_s;
  logic            pending_r, pending_s;
  logic            timeout_err_r, timeout_err_s;
  logic [15:0]     frame_count_r, frame_count_s;

  logic            clr_write_r, clr_write_s;
  logic            draw_r, draw_s;
  logic            busy_r, busy_s;
  logic [9:0]      x_r, x_s;
  logic [8:0]      y_r, y_s;
  logic [8:0]      color_r, color_s;

  // State, scan/timeout counters and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cx_r          <= 10'd0;
      cy_r          <= 9'd0;
      tcnt_r        <= '0;
      pending_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      state_r       <= state_s;
      cx_r          <= cx_s;
      cy_r          <= cy_s;
      tcnt_r        <= tcnt_s;
      pending_r     <= pending_s;
      timeout_err_r <= timeout_err_s;
      frame_count_r <= frame_count_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_s       = state_r;
    cx_s          = cx_r;
    cy_s          = cy_r;
    tcnt_s        = tcnt_r;
    pending_s     = pending_r;
    timeout_err_s = timeout_err_r;
    frame_count_s = frame_count_r;
    // A request while busy is remembered once; repeats collapse onto the same flag
    if ((state_r != ST_IDLE) && refresh_req) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
    case (state_r)
      ST_IDLE: begin
        cx_s   = 10'd0;
        cy_s   = 9'd0;
        tcnt_s = '0;
        if (refresh_req || pending_r) begin
          state_s   = ST_CLEAR;
          pending_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cx_r == CX_LAST) begin
          cx_s = 10'd0;
          if (cy_r == CY_LAST) begin
            cy_s    = 9'd0;
            state_s = ST_ARM;
          end else begin
            cy_s = cy_r + 9'd1;
          end
        end else begin
          cx_s = cx_r + 10'd1;
        end
      end
      ST_ARM: begin
        tcnt_s  = '0;
        state_s = ST_DRAW;
      end
      ST_DRAW: begin
        if (pipeline_done) begin
          state_s = ST_FINISH;
        end else if (tcnt_r == T_LAST) begin
          timeout_err_s = 1'b1;
          state_s       = ST_FINISH;
        end else begin
          tcnt_s = tcnt_r + 1'b1;
        end
      end
      ST_FINISH: begin
        tcnt_s        = '0;
        frame_count_s = frame_count_r + 16'd1;
        state_s       = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, registered below
  always_comb begin
    clr_write_s = 1'b0;
    draw_s      = 1'b0;
    busy_s      = 1'b0;
    x_s         = 10'd0;
    y_s         = 9'd0;
    color_s     = 9'd0;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_CLEAR: begin
        busy_s      = 1'b1;
        clr_write_s = 1'b1;
        x_s         = X0_L + cx_s;
        y_s         = Y0_L + cy_s;
        color_s     = BG_COLOR;
      end
      ST_ARM, ST_FINISH: begin
        busy_s = 1'b1;
      end
      ST_DRAW: begin
        busy_s = 1'b1;
        draw_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_write_r <= 1'b0;
      draw_r      <= 1'b0;
      busy_r      <= 1'b0;
      x_r         <= 10'd0;
      y_r         <= 9'd0;
      color_r     <= 9'd0;
    end else begin
      clr_write_r <= clr_write_s;
      draw_r      <= draw_s;
      busy_r      <= busy_s;
      x_r         <= x_s;
      y_r         <= y_s;
      color_r     <= color_s;
    end
  end

  // While drawing, the drawer's pixel goes straight through so no cycle is lost
  assign vga_x         = draw_r ? pipeline_x     : x_r;
  assign vga_y         = draw_r ? pipeline_y     : y_r;
  assign vga_color     = draw_r ? pipeline_color : color_r;
  assign vga_write     = draw_r ? ~pipeline_done : clr_write_r;
  assign drawer_resetn = draw_r;
  assign busy          = busy_r;
  assign timeout_err   = timeout_err_r;
  assign frame_count   = frame_count_r;

endmodule

// File: tb/tb_vga_draw_sequencer.sv
// Directed bench for vga_draw_sequencer: a pixel-index model of the redraw
// sequence is compared against the outputs every cycle, plus literal spot checks.
module tb_vga_draw_sequencer;

  localparam int X0 = 300;
  localparam int Y0 = 25;
  localparam int W  = 117;
  localparam int H  = 68;
  localparam int TO = 8192;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        refresh_req = 1'b0;
  logic [9:0]  pipeline_x = 10'd0;
  logic [8:0]  pipeline_y = 9'd0;
  logic [8:0]  pipeline_color = 9'd0;
  logic        pipeline_done = 1'b0;
  logic        drawer_resetn;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [8:0]  vga_color;
  logic        vga_write;
  logic        busy;
  logic        timeout_err;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  vga_draw_sequencer dut (
    .clock(clock), .reset(reset), .refresh_req(refresh_req),
    .pipeline_x(pipeline_x), .pipeline_y(pipeline_y),
    .pipeline_color(pipeline_color), .pipeline_done(pipeline_done),
    .drawer_resetn(drawer_resetn), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_write(vga_write), .busy(busy),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drawer stand-in: emits pixel k = 0,1,2,... after release, done after draw_len pixels
  int draw_len = 20;
  initial begin
    int  k;
    bit  prev;
    k = 0;
    prev = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!drawer_resetn) k = 0;
      else if (prev) k++;
      prev = drawer_resetn;
      pipeline_done  = drawer_resetn && (k >= draw_len);
      pipeline_x     = 10'((k * 37 + 5) % 1024);
      pipeline_y     = 9'((k * 11 + 3) % 512);
      pipeline_color = 9'(k % 512);
    end
  end

  // Model: phase plus elapsed cycles in that phase; clear pixel comes from the index
  int          m_ph;   // 0 idle, 1 clear, 2 arm, 3 draw, 4 finish
  int          m_t;
  bit          m_pend;
  bit          m_err;
  logic [15:0] m_frames;
  logic [15:0] frame_base = 16'd0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph <= 0; m_t <= 0; m_pend <= 1'b0; m_err <= 1'b0; m_frames <= 16'd0;
    end else begin
      if (m_ph != 0 && refresh_req) m_pend <= 1'b1;
      case (m_ph)
        0: if (refresh_req || m_pend) begin m_ph <= 1; m_t <= 0; m_pend <= 1'b0; end
        1: begin
          m_t <= m_t + 1;
          if (m_t == W * H - 1) m_ph <= 2;
        end
        2: begin m_ph <= 3; m_t <= 0; end
        3: begin
          if (pipeline_done) m_ph <= 4;
          else if (m_t == TO - 1) begin m_err <= 1'b1; m_ph <= 4; end
          else m_t <= m_t + 1;
        end
        4: begin m_frames <= m_frames + 16'd1; m_ph <= 0; end
        default: m_ph <= 0;
      endcase
    end
  end

  // Per-cycle comparison and frame statistics
  int          clr_cnt = 0;
  int          draw_cnt = 0;
  int          gap_cnt = 0;
  int          color_bad = 0;
  logic [18:0] first_xy = 19'd0;
  logic [18:0] last_xy = 19'd0;
  initial begin
    logic [47:0] act, exp;
    logic [9:0]  ex;
    logic [8:0]  ey, ec;
    logic        ew, er;
    bit          prev_clr, in_gap;
    prev_clr = 1'b0;
    in_gap = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        ex = 10'd0; ey = 9'd0; ec = 9'd0; ew = 1'b0; er = 1'b0;
        if (m_ph == 1) begin
          ex = 10'(X0 + m_t % W);
          ey = 9'(Y0 + m_t / W);
          ew = 1'b1;
        end else if (m_ph == 3) begin
          ex = pipeline_x; ey = pipeline_y; ec = pipeline_color;
          ew = ~pipeline_done; er = 1'b1;
        end
        exp = {ex, ey, ec, ew, er, (m_ph != 0), m_err, m_frames + frame_base};
        act = {vga_x, vga_y, vga_color, vga_write, drawer_resetn, busy, timeout_err, frame_count};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, act, exp);
        end
        if (vga_write && !drawer_resetn) begin
          if (!prev_clr) begin first_xy = {vga_x, vga_y}; gap_cnt = 0; end
          last_xy = {vga_x, vga_y};
          if (vga_color != 9'd0) color_bad++;
          clr_cnt++;
          in_gap = 1'b1;
          prev_clr = 1'b1;
        end else begin
          prev_clr = 1'b0;
          if (drawer_resetn) in_gap = 1'b0;
          else if (in_gap) gap_cnt++;
          if (vga_write && drawer_resetn) draw_cnt++;
        end
      end else begin
        prev_clr = 1'b0;
        in_gap = 1'b0;
      end
    end
  end

  task automatic start_frame;
    @(posedge clock); #1;
    refresh_req = 1'b1;
    chk("busy_before_req", busy, 0);
    @(posedge clock); #1;
    refresh_req = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < budget);
    chk("idle_reached", busy, 0);
  endtask

  task automatic do_reset;
    @(posedge clock); #1;
    reset = 1'b1;
    frame_base = 16'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  int c0, d0;

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_write", vga_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rn", drawer_resetn, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_color}, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_err", timeout_err, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Idle refresh and draw handoff
    draw_len = 4160;
    c0 = clr_cnt; d0 = draw_cnt;
    start_frame();
    wait_idle(20000);
    chk("clear_writes", clr_cnt - c0, 7956);
    chk("first_pixel", first_xy, {10'd300, 9'd25});
    chk("last_pixel", last_xy, {10'd416, 9'd92});
    chk("clear_color", color_bad, 0);
    chk("arm_cycles", gap_cnt, 1);
    chk("draw_writes", draw_cnt - d0, 4160);
    chk("frames_a", frame_count, 1);
    chk("err_a", timeout_err, 0);

    // Pending: three requests during CLEAR give one extra frame
    do_reset();
    draw_len = 20;
    c0 = clr_cnt; d0 = draw_cnt;
    start_frame();
    repeat (3) begin
      repeat (50) @(posedge clock);
      #1 refresh_req = 1'b1;
      @(posedge clock); #1 refresh_req = 1'b0;
    end
    wait_idle(20000);
    chk("frames_p1", frame_count, 1);
    @(negedge clock);
    chk("pending_restart", busy, 1);
    wait_idle(20000);
    repeat (30) @(negedge clock);
    chk("pending_idle", busy, 0);
    chk("pending_frames", frame_count, 2);
    chk("pending_clear", clr_cnt - c0, 2 * 7956);
    chk("pending_draw", draw_cnt - d0, 40);

    // Timeout, then a good frame leaves the error set
    do_reset();
    draw_len = 1 << 30;
    d0 = draw_cnt;
    start_frame();
    wait_idle(20000);
    chk("to_err", timeout_err, 1);
    chk("to_frames", frame_count, 1);
    chk("to_draw", draw_cnt - d0, 8192);
    draw_len = 5;
    start_frame();
    wait_idle(20000);
    chk("to_err_sticky", timeout_err, 1);
    chk("to_frames2", frame_count, 2);

    // Reset in the middle of CLEAR
    do_reset();
    draw_len = 20;
    start_frame();
    repeat (3000) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_write", vga_write, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clock); #1 reset = 1'b0;
    c0 = clr_cnt;
    repeat (50) @(negedge clock);
    chk("mid_rst_quiet", clr_cnt - c0, 0);
    start_frame();
    repeat (3) @(negedge clock);
    chk("mid_rst_restart", first_xy, {10'd300, 9'd25});

    // Frame counter wrap from a preloaded 16'hFFFF
    do_reset();
    @(posedge clock); #1;
    force dut.frame_count_r = 16'hFFFF;
    frame_base = 16'hFFFF;
    @(posedge clock); #1;
    release dut.frame_count_r;
    @(negedge clock);
    chk("wrap_preload", frame_count, 16'hFFFF);
    draw_len = 1;
    start_frame();
    wait_idle(20000);
    chk("wrap_zero", frame_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
